// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, BMODE baud table and divisor
// helper, and the UMODE/SMODE field decode used by both transmitter and receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_DONE,
        ST_WAIT_HIGH
    } rx_state_e;

    localparam int unsigned UMODE_PAR_BIT    = 2;
    localparam int unsigned SMODE_ODD_BIT    = 0;
    localparam int unsigned SMODE_STOP2_BIT  = 1;
    localparam int unsigned BAUD_TBL_SIZE    = 8;
    localparam logic [2:0]  BAUD_SEL_DEFAULT = 3'd1;

    function automatic int unsigned baud_rate(input logic [2:0] sel);
        case (sel)
            3'd0:    return 32'd4800;
            3'd1:    return 32'd9600;
            3'd2:    return 32'd14400;
            3'd3:    return 32'd19200;
            3'd4:    return 32'd38400;
            3'd5:    return 32'd57600;
            3'd6:    return 32'd115200;
            default: return 32'd9600;
        endcase
    endfunction

    // Out-of-range BMODE codes fall back to 9600.
    function automatic logic [2:0] baud_sel(input logic [4:0] bmode);
        return (bmode < 5'd7) ? bmode[2:0] : BAUD_SEL_DEFAULT;
    endfunction

    function automatic logic [15:0] baud_div(input int unsigned clk_hz, input logic [2:0] sel);
        int unsigned d;
        d = clk_hz / (32'd16 * baud_rate(sel));
        if (d == 32'd0) begin
            d = 32'd1;
        end else if (d > 32'd65535) begin
            d = 32'd65535;
        end
        return d[15:0];
    endfunction

    function automatic logic [3:0] data_len(input logic [1:0] umode_len);
        return 4'd5 + {2'b00, umode_len};
    endfunction

endpackage

// File: rtl/uart_rx_baud.sv
// 16x oversample tick generator: down-counter reloaded with the divisor, plus a
// 4-bit index of the tick within the current bit. Held parked while restart_i is high.
module uart_rx_baud (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        restart_i,
    input  logic [15:0] div_i,
    output logic        tick_o,
    output logic [3:0]  tick_idx_o
);

    logic [15:0] cnt_q;
    logic [3:0]  idx_q;

    assign tick_o     = (cnt_q == 16'd0) && !restart_i;
    assign tick_idx_o = idx_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else if (restart_i) begin
            cnt_q <= div_i - 16'd1;
            idx_q <= '0;
        end else if (cnt_q == 16'd0) begin
            cnt_q <= div_i - 16'd1;
            idx_q <= idx_q + 4'd1;
        end else begin
            cnt_q <= cnt_q - 16'd1;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver with majority-vote bit sampling and error flags.
// Parity support is compiled in only when UART_RX_PARITY_EN is defined.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic       SCLK,
    input  logic       SCLR_N,
    input  logic       RX,
    input  logic [2:0] UMODE,
    input  logic [1:0] SMODE,
    input  logic [4:0] BMODE,
    output logic [7:0] RX_DATA,
    output logic       RX_DONE,
    output logic       RX_PERR,
    output logic       RX_FERR,
    output logic       RX_BUSY
);

    rx_state_e   state_q;
    logic        rx_meta_q, rx_sync_q, rx_prev_q;
    logic        vote7_q, vote8_q;
    logic [2:0]  sel_q;
    logic [3:0]  nbits_q;
    logic        stop2_q;
    logic [3:0]  bit_cnt_q;
    logic        stop_cnt_q;
    logic [7:0]  shift_q;
    logic        ferr_pend_q;
    logic [7:0]  data_q;
    logic        done_q, ferr_q, busy_q;

    logic [15:0] div_tbl [BAUD_TBL_SIZE];
    logic [2:0]  div_sel;
    logic        restart, tick, rx_fall, mid, vote;
    logic [3:0]  tick_idx;

    for (genvar g = 0; g < BAUD_TBL_SIZE; g++) begin : g_div
        assign div_tbl[g] = baud_div(CLK_HZ, 3'(g));
    end

    // While idle the counter tracks the live BMODE so the first bit after a
    // start edge already runs at the rate that gets latched on that edge.
    assign div_sel = (state_q == ST_IDLE) ? baud_sel(BMODE) : sel_q;
    assign restart = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_WAIT_HIGH);
    assign rx_fall = rx_prev_q && !rx_sync_q;
    assign mid     = tick && (tick_idx == 4'd9);
    assign vote    = (vote7_q & vote8_q) | (vote7_q & rx_sync_q) | (vote8_q & rx_sync_q);

    uart_rx_baud u_baud (
        .clk_i      (SCLK),
        .rst_ni     (SCLR_N),
        .restart_i  (restart),
        .div_i      (div_tbl[div_sel]),
        .tick_o     (tick),
        .tick_idx_o (tick_idx)
    );

    // Synchronizer resets to the idle-high level so reset release is not seen as an edge.
    always_ff @(posedge SCLK or negedge SCLR_N) begin
        if (!SCLR_N) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_en_q, odd_q, perr_pend_q, perr_q;
    assign RX_PERR = perr_q;
`else
    logic unused_par_cfg;
    assign unused_par_cfg = ^{UMODE[UMODE_PAR_BIT], SMODE[SMODE_ODD_BIT]};
    assign RX_PERR = 1'b0;
`endif

    always_ff @(posedge SCLK or negedge SCLR_N) begin
        if (!SCLR_N) begin
            state_q     <= ST_IDLE;
            vote7_q     <= 1'b1;
            vote8_q     <= 1'b1;
            sel_q       <= BAUD_SEL_DEFAULT;
            nbits_q     <= 4'd8;
            stop2_q     <= 1'b0;
            bit_cnt_q   <= '0;
            stop_cnt_q  <= 1'b0;
            shift_q     <= '0;
            ferr_pend_q <= 1'b0;
            data_q      <= '0;
            done_q      <= 1'b0;
            ferr_q      <= 1'b0;
            busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_en_q    <= 1'b0;
            odd_q       <= 1'b0;
            perr_pend_q <= 1'b0;
            perr_q      <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (tick && tick_idx == 4'd7) vote7_q <= rx_sync_q;
            if (tick && tick_idx == 4'd8) vote8_q <= rx_sync_q;

            case (state_q)
                ST_IDLE: begin
                    if (rx_fall) begin
                        state_q     <= ST_START;
                        busy_q      <= 1'b1;
                        sel_q       <= baud_sel(BMODE);
                        nbits_q     <= data_len(UMODE[1:0]);
                        stop2_q     <= SMODE[SMODE_STOP2_BIT];
                        stop_cnt_q  <= 1'b0;
                        shift_q     <= '0;
                        ferr_pend_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
                        par_en_q    <= UMODE[UMODE_PAR_BIT];
                        odd_q       <= SMODE[SMODE_ODD_BIT];
                        perr_pend_q <= 1'b0;
`endif
                    end
                end
                ST_START: begin
                    if (mid) begin
                        if (vote) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q   <= ST_DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                end
                ST_DATA: begin
                    if (mid) begin
                        shift_q[bit_cnt_q[2:0]] <= vote;
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q == nbits_q - 4'd1) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= par_en_q ? ST_PARITY : ST_STOP;
`else
                            state_q <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (mid) begin
                        if (vote != (^shift_q ^ odd_q)) perr_pend_q <= 1'b1;
                        state_q <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (mid) begin
                        if (!vote) ferr_pend_q <= 1'b1;
                        if (stop2_q && !stop_cnt_q) begin
                            stop_cnt_q <= 1'b1;
                        end else begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    data_q <= shift_q;
                    ferr_q <= ferr_pend_q;
                    done_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                    perr_q <= perr_pend_q;
`endif
                    if (ferr_pend_q) begin
                        state_q <= ST_WAIT_HIGH;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rx_sync_q) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign RX_DATA = data_q;
    assign RX_DONE = done_q;
    assign RX_FERR = ferr_q;
    assign RX_BUSY = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames
// compared against a bit-stream reference model.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int unsigned CLK_HZ   = 1_536_000;
    localparam int          BIT_CLKS = 160;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       SCLK = 1'b0;
    logic       SCLR_N;
    logic       RX;
    logic [2:0] UMODE;
    logic [1:0] SMODE;
    logic [4:0] BMODE;
    logic [7:0] RX_DATA;
    logic       RX_DONE, RX_PERR, RX_FERR, RX_BUSY;

    uart_rx #(.CLK_HZ(CLK_HZ)) dut (
        .SCLK    (SCLK),
        .SCLR_N  (SCLR_N),
        .RX      (RX),
        .UMODE   (UMODE),
        .SMODE   (SMODE),
        .BMODE   (BMODE),
        .RX_DATA (RX_DATA),
        .RX_DONE (RX_DONE),
        .RX_PERR (RX_PERR),
        .RX_FERR (RX_FERR),
        .RX_BUSY (RX_BUSY)
    );

    always #5 SCLK = ~SCLK;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         cyc;
    } strobe_t;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    int      cyc = 0;
    int      total = 0;
    int      bad = 0;
    strobe_t strobes[$];
    bit      line_q[$];

    always @(posedge SCLK) cyc++;

    always @(negedge SCLK) begin
        if (RX_DONE === 1'b1)
            strobes.push_back('{data: RX_DATA, perr: RX_PERR, ferr: RX_FERR, cyc: cyc});
    end

    // Line-level image of one transmitted frame: start, data LSB first, optional parity, stops.
    task automatic build_line(input logic [7:0] d, input logic [2:0] um, input logic [1:0] sm, input bit flip);
        int n;
        bit p;
        n = 5 + int'(um[1:0]);
        p = sm[0];
        line_q.delete();
        line_q.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            line_q.push_back(d[i]);
            p ^= d[i];
        end
        if (um[2]) line_q.push_back(p ^ flip);
        line_q.push_back(1'b1);
        if (sm[1]) line_q.push_back(1'b1);
    endtask

    // What a receiver configured with um/sm reports for the stream in line_q.
    function automatic exp_t model_rx(input logic [2:0] um, input logic [1:0] sm);
        exp_t e;
        int   pos;
        int   n;
        bit   ones;
        bit   b;
        e    = '{data: 8'h00, perr: 1'b0, ferr: 1'b0};
        pos  = 1;
        n    = 5 + int'(um[1:0]);
        ones = 1'b0;
        for (int i = 0; i < n; i++) begin
            b = (pos < line_q.size()) ? line_q[pos] : 1'b1;
            pos++;
            e.data[i] = b;
            ones ^= b;
        end
        if (PAR_EN && um[2]) begin
            b = (pos < line_q.size()) ? line_q[pos] : 1'b1;
            pos++;
            e.perr = (b != (ones ^ sm[0]));
        end
        for (int s = 0; s < (sm[1] ? 2 : 1); s++) begin
            b = (pos < line_q.size()) ? line_q[pos] : 1'b1;
            pos++;
            if (!b) e.ferr = 1'b1;
        end
        return e;
    endfunction

    task automatic send_line(input bit scramble);
        logic [2:0] um_s;
        logic [1:0] sm_s;
        logic [4:0] bm_s;
        um_s = UMODE;
        sm_s = SMODE;
        bm_s = BMODE;
        for (int i = 0; i < line_q.size(); i++) begin
            if (scramble && i == 1) begin
                UMODE = 3'($urandom);
                SMODE = 2'($urandom);
                BMODE = 5'($urandom);
            end
            if (scramble && i == line_q.size() - 1) begin
                UMODE = um_s;
                SMODE = sm_s;
                BMODE = bm_s;
            end
            RX = line_q[i];
            repeat (BIT_CLKS) @(negedge SCLK);
        end
    endtask

    task automatic xfer(input logic [7:0] d, input logic [2:0] um, input logic [1:0] sm,
                        input bit flip, input bit scramble, input int idle,
                        output exp_t e, output int nstrobe, output strobe_t got);
        UMODE = um;
        SMODE = sm;
        strobes.delete();
        build_line(d, um, sm, flip);
        e = model_rx(um, sm);
        send_line(scramble);
        repeat (idle) @(negedge SCLK);
        nstrobe = strobes.size();
        if (nstrobe > 0) got = strobes[0];
        else got = '{data: 8'hxx, perr: 1'bx, ferr: 1'bx, cyc: 0};
    endtask

    task automatic test_reset();
        SCLR_N = 1'b0;
        RX     = 1'b1;
        UMODE  = 3'b011;
        SMODE  = 2'b00;
        BMODE  = 5'd1;
        repeat (3) @(negedge SCLK);
        total++; if (RX_DATA !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", RX_DATA); end
        total++; if (RX_DONE !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", RX_DONE); end
        total++; if (RX_PERR !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b want=0", RX_PERR); end
        total++; if (RX_FERR !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b want=0", RX_FERR); end
        total++; if (RX_BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", RX_BUSY); end
        SCLR_N = 1'b1;
        repeat (50) @(negedge SCLK);
        total++; if (RX_BUSY !== 1'b0) begin bad++; $display("FAIL post_reset_busy got=%b want=0", RX_BUSY); end
        total++; if (strobes.size() !== 0) begin bad++; $display("FAIL post_reset_strobes got=%0d want=0", strobes.size()); end
    endtask

    task automatic test_8n1();
        exp_t e; int n; strobe_t g;
        xfer(8'hA1, 3'b011, 2'b00, 1'b0, 1'b0, 20, e, n, g);
        total++; if (n !== 1) begin bad++; $display("FAIL 8n1_count got=%0d want=1", n); end
        total++; if (g.data !== 8'hA1) begin bad++; $display("FAIL 8n1_data got=%h want=a1", g.data); end
        total++; if (g.perr !== 1'b0 || g.ferr !== 1'b0) begin bad++; $display("FAIL 8n1_err got=%b%b want=00", g.perr, g.ferr); end
        total++; if (RX_BUSY !== 1'b0) begin bad++; $display("FAIL 8n1_busy got=%b want=0", RX_BUSY); end
    endtask

    task automatic test_7e1();
        exp_t e; int n; strobe_t g;
        xfer(8'h35, 3'b110, 2'b00, 1'b0, 1'b0, 20, e, n, g);
        total++; if (n !== 1) begin bad++; $display("FAIL 7e1_good_count got=%0d want=1", n); end
        total++; if (g.data !== e.data) begin bad++; $display("FAIL 7e1_good_data got=%h want=%h", g.data, e.data); end
        total++; if (g.perr !== e.perr || g.ferr !== e.ferr) begin bad++; $display("FAIL 7e1_good_err got=%b%b want=%b%b", g.perr, g.ferr, e.perr, e.ferr); end
        xfer(8'h35, 3'b110, 2'b00, 1'b1, 1'b0, 200, e, n, g);
        total++; if (n !== 1) begin bad++; $display("FAIL 7e1_bad_count got=%0d want=1", n); end
        total++; if (g.data !== e.data) begin bad++; $display("FAIL 7e1_bad_data got=%h want=%h", g.data, e.data); end
        total++; if (g.perr !== e.perr || g.ferr !== e.ferr) begin bad++; $display("FAIL 7e1_bad_err got=%b%b want=%b%b", g.perr, g.ferr, e.perr, e.ferr); end
    endtask

    task automatic test_glitch();
        bit seen_busy;
        bit idle_again;
        UMODE = 3'b011;
        SMODE = 2'b00;
        strobes.delete();
        seen_busy  = 1'b0;
        idle_again = 1'b0;
        RX = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge SCLK);
            if (RX_BUSY === 1'b1) seen_busy = 1'b1;
        end
        RX = 1'b1;
        for (int i = 0; i < 100 && !idle_again; i++) begin
            @(negedge SCLK);
            if (RX_BUSY === 1'b0) idle_again = 1'b1;
        end
        repeat (300) @(negedge SCLK);
        total++; if (seen_busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_rise got=%b want=1", seen_busy); end
        total++; if (idle_again !== 1'b1) begin bad++; $display("FAIL glitch_busy_fall got=%b want=1 within 100 clocks", idle_again); end
        total++; if (strobes.size() !== 0) begin bad++; $display("FAIL glitch_strobes got=%0d want=0", strobes.size()); end
    endtask

    task automatic test_break();
        exp_t e; int n; strobe_t g;
        UMODE = 3'b011;
        SMODE = 2'b00;
        strobes.delete();
        RX = 1'b0;
        repeat (3000) @(negedge SCLK);
        total++; if (strobes.size() !== 1) begin bad++; $display("FAIL break_count got=%0d want=1", strobes.size()); end
        if (strobes.size() > 0) g = strobes[0];
        else g = '{data: 8'hxx, perr: 1'bx, ferr: 1'bx, cyc: 0};
        total++; if (g.data !== 8'h00) begin bad++; $display("FAIL break_data got=%h want=00", g.data); end
        total++; if (g.ferr !== 1'b1) begin bad++; $display("FAIL break_ferr got=%b want=1", g.ferr); end
        total++; if (RX_BUSY !== 1'b1) begin bad++; $display("FAIL break_busy_hold got=%b want=1", RX_BUSY); end
        RX = 1'b1;
        repeat (50) @(negedge SCLK);
        total++; if (RX_BUSY !== 1'b0) begin bad++; $display("FAIL break_recover_busy got=%b want=0", RX_BUSY); end
        total++; if (strobes.size() !== 1) begin bad++; $display("FAIL break_extra_strobes got=%0d want=1", strobes.size()); end
        xfer(8'h5A, 3'b011, 2'b00, 1'b0, 1'b0, 20, e, n, g);
        total++; if (n !== 1 || g.data !== 8'h5A) begin bad++; $display("FAIL break_follow got=%0d/%h want=1/5a", n, g.data); end
        total++; if (g.ferr !== 1'b0 || g.perr !== 1'b0) begin bad++; $display("FAIL break_follow_err got=%b%b want=00", g.perr, g.ferr); end
    endtask

    task automatic test_reset_midframe();
        exp_t e; int n; strobe_t g;
        UMODE = 3'b011;
        SMODE = 2'b00;
        strobes.delete();
        build_line(8'hC3, 3'b011, 2'b00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            RX = line_q[i];
            repeat (BIT_CLKS) @(negedge SCLK);
        end
        RX = line_q[4];
        repeat (80) @(negedge SCLK);
        total++; if (RX_BUSY !== 1'b1) begin bad++; $display("FAIL midreset_busy_before got=%b want=1", RX_BUSY); end
        #2 SCLR_N = 1'b0;
        #1;
        total++; if (RX_DATA !== 8'h00) begin bad++; $display("FAIL midreset_data got=%h want=00", RX_DATA); end
        total++; if (RX_BUSY !== 1'b0 || RX_DONE !== 1'b0) begin bad++; $display("FAIL midreset_busy_done got=%b%b want=00", RX_BUSY, RX_DONE); end
        total++; if (RX_PERR !== 1'b0 || RX_FERR !== 1'b0) begin bad++; $display("FAIL midreset_err got=%b%b want=00", RX_PERR, RX_FERR); end
        RX = 1'b1;
        repeat (3) @(negedge SCLK);
        SCLR_N = 1'b1;
        repeat (400) @(negedge SCLK);
        total++; if (strobes.size() !== 0) begin bad++; $display("FAIL midreset_strobes got=%0d want=0", strobes.size()); end
        xfer(8'h5A, 3'b011, 2'b00, 1'b0, 1'b0, 20, e, n, g);
        total++; if (n !== 1 || g.data !== 8'h5A) begin bad++; $display("FAIL midreset_follow got=%0d/%h want=1/5a", n, g.data); end
    endtask

    task automatic test_back_to_back();
        exp_t ea, eb;
        UMODE = 3'b011;
        SMODE = 2'b10;
        strobes.delete();
        build_line(8'h00, 3'b011, 2'b10, 1'b0);
        ea = model_rx(3'b011, 2'b10);
        send_line(1'b0);
        build_line(8'hFF, 3'b011, 2'b10, 1'b0);
        eb = model_rx(3'b011, 2'b10);
        send_line(1'b0);
        repeat (20) @(negedge SCLK);
        total++; if (strobes.size() !== 2) begin bad++; $display("FAIL b2b_count got=%0d want=2", strobes.size()); end
        if (strobes.size() >= 2) begin
            total++; if (strobes[0].data !== ea.data || strobes[1].data !== eb.data) begin bad++; $display("FAIL b2b_data got=%h,%h want=%h,%h", strobes[0].data, strobes[1].data, ea.data, eb.data); end
            total++; if ({strobes[0].perr, strobes[0].ferr, strobes[1].perr, strobes[1].ferr} !== 4'b0000) begin bad++; $display("FAIL b2b_err got=%b%b%b%b want=0000", strobes[0].perr, strobes[0].ferr, strobes[1].perr, strobes[1].ferr); end
            total++; if (strobes[1].cyc - strobes[0].cyc !== 1760) begin bad++; $display("FAIL b2b_spacing got=%0d want=1760", strobes[1].cyc - strobes[0].cyc); end
        end
    endtask

    task automatic test_random();
        exp_t e; int n; strobe_t g;
        logic [2:0] um;
        logic [1:0] sm;
        logic [7:0] d;
        bit flip;
        for (int k = 0; k < 10; k++) begin
            um   = 3'($urandom);
            sm   = 2'($urandom);
            d    = 8'($urandom);
            flip = um[2] && ($urandom_range(0, 2) == 0);
            xfer(d, um, sm, flip, 1'b1, $urandom_range(0, 200), e, n, g);
            total++; if (n !== 1) begin bad++; $display("FAIL rand%0d_count got=%0d want=1", k, n); end
            total++; if (g.data !== e.data) begin bad++; $display("FAIL rand%0d_data got=%h want=%h um=%b sm=%b", k, g.data, e.data, um, sm); end
            total++; if (g.perr !== e.perr || g.ferr !== e.ferr) begin bad++; $display("FAIL rand%0d_err got=%b%b want=%b%b um=%b sm=%b", k, g.perr, g.ferr, e.perr, e.ferr, um, sm); end
        end
        repeat (400) @(negedge SCLK);
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_7e1();
        test_glitch();
        test_break();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
